mux2_rr_arbiter: RTL

Round-robin arbiter that shares one 2:1 data mux between two packet requesters and drives its select line. Each requester presents a valid/data/last stream. The arbiter locks the mux to one requester for a whole packet, then hands off fairly. It sits in front of the shared 2:1 mux and produces a single valid/ready output stream for the downstream consumer.

---
 rtl/mux2_rr_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin owner of a shared 2:1 data mux.
// Locks the mux to one requester per packet, then hands off fairly.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req0/data0/last0  requester 0 beat stream
//   req1/data1/last1  requester 1 beat stream
//   gnt0, gnt1        beat accepted from requester n this cycle
//   sel               mux select (0 = requester 0, 1 = requester 1)
//   out_valid/out_data/out_last/out_ready  downstream stream
//   busy              a grant is held
//   err               one-cycle pulse after a forced release
module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             last0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  input  logic             last1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             err
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t          state;
  logic            prio;
  logic [CW-1:0]   cnt;

  logic cur_req;
  logic cur_last;
  logic other_req;
  logic xfer;
  logic at_limit;
  logic release_pkt;

  always_comb begin
    cur_req   = 1'b0;
    cur_last  = 1'b0;
    other_req = 1'b0;
    case (state)
      GRANT0: begin
        cur_req   = req0;
        cur_last  = last0;
        other_req = req1;
      end
      GRANT1: begin
        cur_req   = req1;
        cur_last  = last1;
        other_req = req0;
      end
      default: begin
        cur_req   = 1'b0;
        cur_last  = 1'b0;
        other_req = 1'b0;
      end
    endcase
  end

  assign sel       = (state == GRANT1);
  assign busy      = (state != IDLE);
  assign out_valid = cur_req;
  assign out_last  = cur_last;
  assign out_data  = sel ? data1 : data0;

  assign xfer = out_valid & out_ready;
  assign gnt0 = xfer & (state == GRANT0);
  assign gnt1 = xfer & (state == GRANT1);

  // This transfer would bring the beat count up to MAX_BEATS.
  assign at_limit    = (cnt == CW'(MAX_BEATS - 1));
  assign release_pkt = xfer & (cur_last | at_limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prio  <= 1'b0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          // Tie goes to prio; a lone request wins outright.
          if (req0 & (~req1 | ~prio)) begin
            state <= GRANT0;
          end else if (req1) begin
            state <= GRANT1;
          end
        end
        GRANT0, GRANT1: begin
          if (xfer) begin
            cnt <= cnt + CW'(1);
          end
          if (release_pkt) begin
            prio  <= ~sel;
            cnt   <= '0;
            // Limit hit without last: packet is cut short.
            err   <= ~cur_last;
            // Go straight to the waiting peer, no idle bubble.
            if (other_req) begin
              state <= sel ? GRANT0 : GRANT1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
